md_ctrl: RTL and testbench

- Sequencing controller between the EX stage and the iterative multiply/divide unit (MD).
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from EX, issues a Start pulse with operands and mode bits to MD, and waits for MD Busy to complete.
- Owns the architectural HI/LO registers and raises a pipeline stall while an operation is in flight.

---
 rtl/md_pkg.sv | 23 ++
 rtl/md_hilo_regs.sv | 40 ++++
 rtl/md_ctrl.sv | 145 ++++++++++++++
 tb/tb_md_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - opcode, state and width definitions shared by the md_ctrl slice
package md_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [3:0] NOP   = 4'd0;
  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] MTHI  = 4'd5;
  localparam logic [3:0] MTLO  = 4'd6;
  localparam logic [3:0] MFHI  = 4'd7;
  localparam logic [3:0] MFLO  = 4'd8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    COMMIT = 2'd3
  } md_state_t;

endpackage

// File: rtl/md_hilo_regs.sv
// rtl/md_hilo_regs.sv - architectural HI/LO storage with MT and commit write ports
// A commit write and an MT write never coincide; commit is given priority anyway.
module md_hilo_regs #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mt_hi_we,
  input  logic             mt_lo_we,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             commit_we,
  input  logic [WIDTH-1:0] commit_hi,
  input  logic [WIDTH-1:0] commit_lo,
  input  logic             rd_hi,
  input  logic             rd_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (commit_we) begin
      hi <= commit_hi;
      lo <= commit_lo;
    end else begin
      if (mt_hi_we) hi <= mt_data;
      if (mt_lo_we) lo <= mt_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_hi)      rd_data = hi;
    else if (rd_lo) rd_data = lo;
  end

endmodule

// File: rtl/md_ctrl.sv
// rtl/md_ctrl.sv - EX-to-MD sequencing controller with HI/LO ownership and watchdog
// Optional MD_FLUSH_EN adds a flush input that aborts an in-flight operation.
module md_ctrl #(
  parameter int WATCHDOG = 64,
  parameter int WIDTH    = md_pkg::MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
`ifdef MD_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             op_valid,
  input  logic [3:0]       op_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             op_ready,
  output logic             stall,
  output logic [WIDTH-1:0] rd_data,
  output logic             md_start,
  output logic             md_sign,
  output logic             md_md,
  output logic [WIDTH-1:0] md_d1,
  output logic [WIDTH-1:0] md_d2,
  input  logic             md_busy,
  input  logic [WIDTH-1:0] md_hi,
  input  logic [WIDTH-1:0] md_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             err
);
  import md_pkg::*;

  localparam int CW = $clog2(WATCHDOG + 1);

  md_state_t     state, nxt;
  logic [CW-1:0] wd_cnt;
  logic          seen_busy;
  logic          accept, ld_ops, mt_hi_we, mt_lo_we, commit_we, wd_fire, abort;
  logic          is_mul, is_div;

  assign is_mul = (op_code == MULT) || (op_code == MULTU);
  assign is_div = (op_code == DIV) || (op_code == DIVU);
  assign stall  = op_valid && !op_ready;

  always_comb begin
    nxt       = state;
    ld_ops    = 1'b0;
    mt_hi_we  = 1'b0;
    mt_lo_we  = 1'b0;
    commit_we = 1'b0;
    wd_fire   = 1'b0;
    md_start  = 1'b0;
    abort     = 1'b0;
`ifdef MD_FLUSH_EN
    // Holding off while MD is still busy keeps a new Start from overlapping an aborted run.
    op_ready = (state == IDLE) && !md_busy;
    abort    = flush && (state != IDLE);
`else
    op_ready = (state == IDLE);
`endif
    accept = op_valid && op_ready;
    case (state)
      IDLE: begin
        if (accept) begin
          // A zero divisor is swallowed here: no Start, HI/LO untouched.
          if (is_mul || (is_div && (op_b != '0))) begin
            ld_ops = 1'b1;
            nxt    = ISSUE;
          end
          mt_hi_we = (op_code == MTHI);
          mt_lo_we = (op_code == MTLO);
        end
      end
      ISSUE: begin
        md_start = 1'b1;
        nxt      = WAIT;
      end
      WAIT: begin
        if (seen_busy && !md_busy) begin
          nxt = COMMIT;
        end else if (wd_cnt == CW'(WATCHDOG - 1)) begin
          wd_fire = 1'b1;
          nxt     = IDLE;
        end
      end
      COMMIT: begin
        commit_we = 1'b1;
        nxt       = IDLE;
      end
      default: nxt = IDLE;
    endcase
    if (abort) begin
      nxt       = IDLE;
      md_start  = 1'b0;
      commit_we = 1'b0;
      wd_fire   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      md_d1     <= '0;
      md_d2     <= '0;
      md_sign   <= 1'b0;
      md_md     <= 1'b0;
      wd_cnt    <= '0;
      seen_busy <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= nxt;
      if (ld_ops) begin
        md_d1   <= op_a;
        md_d2   <= op_b;
        md_sign <= (op_code == MULT) || (op_code == DIV);
        md_md   <= is_div;
      end
      if (state == ISSUE) begin
        wd_cnt    <= '0;
        seen_busy <= 1'b0;
      end else if (state == WAIT) begin
        wd_cnt <= wd_cnt + CW'(1);
        if (md_busy) seen_busy <= 1'b1;
      end
      if (wd_fire) err <= 1'b1;
    end
  end

  md_hilo_regs #(.WIDTH(WIDTH)) u_hilo (
    .clk       (clk),
    .reset     (reset),
    .mt_hi_we  (mt_hi_we),
    .mt_lo_we  (mt_lo_we),
    .mt_data   (op_a),
    .commit_we (commit_we),
    .commit_hi (md_hi),
    .commit_lo (md_lo),
    .rd_hi     (op_code == MFHI),
    .rd_lo     (op_code == MFLO),
    .hi        (hi),
    .lo        (lo),
    .rd_data   (rd_data)
  );

endmodule

// File: tb/tb_md_ctrl.sv
// tb/tb_md_ctrl.sv - scoreboard bench for md_ctrl with a behavioural MD unit
// Covers the MD_FLUSH_EN abort path when that macro is defined.
module tb_md_ctrl;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [3:0]  op_code;
  logic [31:0] op_a, op_b;
  logic        op_ready, stall, md_start, md_sign, md_md, err;
  logic [31:0] rd_data, md_d1, md_d2, hi, lo;
  logic        md_busy = 1'b0;
  logic [31:0] md_hi = '0, md_lo = '0;
`ifdef MD_FLUSH_EN
  logic        flush;
`endif

  always #5 clk = ~clk;

  md_ctrl #(.WATCHDOG(64), .WIDTH(32)) dut (
    .clk(clk), .reset(reset),
`ifdef MD_FLUSH_EN
    .flush(flush),
`endif
    .op_valid(op_valid), .op_code(op_code), .op_a(op_a), .op_b(op_b),
    .op_ready(op_ready), .stall(stall), .rd_data(rd_data),
    .md_start(md_start), .md_sign(md_sign), .md_md(md_md),
    .md_d1(md_d1), .md_d2(md_d2), .md_busy(md_busy),
    .md_hi(md_hi), .md_lo(md_lo), .hi(hi), .lo(lo), .err(err)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] model_op(input bit sgn, input bit dv, input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] q, r;
    logic [63:0] sx, sy;
    if (dv) begin
      if (sgn) begin
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
      end
      return {x % y, x / y};
    end
    sx = sgn ? {{32{x[31]}}, x} : {32'b0, x};
    sy = sgn ? {{32{y[31]}}, y} : {32'b0, y};
    return sx * sy;
  endfunction

  // Behavioural MD: Busy rises the edge after Start and stays up busy_len cycles (forever while hang).
  int busy_len = 10;
  int mcnt = 0;
  bit hang = 0;
  always @(posedge clk) begin
    if (md_start) begin
      md_busy <= 1'b1;
      mcnt    <= busy_len - 1;
      {md_hi, md_lo} <= model_op(md_sign, md_md, md_d1, md_d2);
    end else if (md_busy && !hang) begin
      if (mcnt == 0) md_busy <= 1'b0;
      else mcnt <= mcnt - 1;
    end
  end

  int cyc = 0, acc_cyc = 0, start_cyc = 0, start_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (op_valid && op_ready) acc_cyc <= cyc;
    if (md_start) begin
      start_cyc <= cyc;
      start_cnt <= start_cnt + 1;
    end
  end

  typedef struct {
    string       tag;
    bit          is_rd;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
  } exp_t;
  exp_t sb[$];
  logic [31:0] ref_hi = '0, ref_lo = '0;

  task automatic flush_hilo();
    exp_t e;
    while (sb.size() > 0 && !sb[0].is_rd) begin
      e = sb.pop_front();
      chk(e.tag, {hi, lo}, {e.e_hi, e.e_lo});
    end
  endtask

  task automatic hw_reset(input int ncyc, input bit chk_ready);
    exp_t e;
    reset = 1'b0;
    op_valid = 1'b0;
    repeat (ncyc) @(posedge clk);
    #1;
    ref_hi = '0;
    ref_lo = '0;
    sb.delete();
    sb.push_back('{"reset_hilo", 1'b0, ref_hi, ref_lo});
    flush_hilo();
    chk("reset_md_start", md_start, 0);
    chk("reset_err", err, 0);
    if (chk_ready) chk("reset_op_ready", op_ready, 1);
    reset = 1'b1;
  endtask

  // Starts and ends at posedge+1; counts stalled cycles before acceptance.
  task automatic send(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                      input bit abort, output int stalls);
    bit got;
    exp_t e;
    got = 0;
    stalls = 0;
    op_valid = 1'b1;
    op_code = code;
    op_a = a;
    op_b = b;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (op_ready) begin
        got = 1;
        break;
      end
      if (stall) stalls++;
    end
    if (!got) chk("accept_timeout", 64'(got), 1);
    flush_hilo();
    case (code)
      MULT, MULTU, DIV, DIVU: begin
        if (!abort && !((code == DIV || code == DIVU) && b == 0))
          {ref_hi, ref_lo} = model_op(code == MULT || code == DIV, code == DIV || code == DIVU, a, b);
        sb.push_back('{"arith_hilo", 1'b0, ref_hi, ref_lo});
      end
      MTHI: begin ref_hi = a; sb.push_back('{"mthi_hilo", 1'b0, ref_hi, ref_lo}); end
      MTLO: begin ref_lo = a; sb.push_back('{"mtlo_hilo", 1'b0, ref_hi, ref_lo}); end
      MFHI, MFLO: begin
        sb.push_back('{(code == MFHI) ? "mfhi_rd" : "mflo_rd", 1'b1, (code == MFHI) ? ref_hi : ref_lo, 32'd0});
        e = sb.pop_front();
        chk(e.tag, rd_data, e.e_hi);
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_code = NOP;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (op_ready) break;
    end
    flush_hilo();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_md_idle();
    int i;
    for (i = 0; i < 200; i++) begin
      if (!md_busy) break;
      @(posedge clk);
      #1;
    end
    if (i == 200) chk("md_idle_timeout", 0, 1);
  endtask

  int st, s0, div_acc, n;

  initial begin
    reset = 1'b0;
    op_valid = 1'b0;
    op_code = NOP;
    op_a = '0;
    op_b = '0;
`ifdef MD_FLUSH_EN
    flush = 1'b0;
`endif
    @(posedge clk);
    #1;
    hw_reset(2, 1);

    busy_len = 10;
    s0 = start_cnt;
    send(DIV, 32'd85, 32'd2, 0, st);
    div_acc = acc_cyc;
    send(MFLO, 0, 0, 0, st);
    chk("div_stall", st, 13);
    chk("div_start_lat", start_cyc - div_acc, 1);
    chk("div_start_cnt", start_cnt - s0, 1);
    chk("div_md_md", md_md, 1);
    chk("div_md_sign", md_sign, 1);
    chk("div_md_d1", md_d1, 85);
    chk("div_md_d2", md_d2, 2);

    busy_len = 5;
    send(MULTU, 32'hFFFF_FFFF, 32'd2, 0, st);
    send(MFLO, 0, 0, 0, st);
    chk("multu_stall", st, 8);
    chk("multu_sign", md_sign, 0);
    send(MFHI, 0, 0, 0, st);
    chk("mfhi_after_multu_stall", st, 0);

    send(MTHI, 32'h1234, 0, 0, st);
    send(MFHI, 0, 0, 0, st);
    chk("mthi_mfhi_stall", st, 0);

    busy_len = 3;
    send(MULT, 32'hFFFF_FFFD, 32'd5, 0, st);
    send(NOP, 0, 0, 0, st);
    chk("mult_stall", st, 6);

    s0 = start_cnt;
    send(DIV, 32'd7, 32'd0, 0, st);
    send(NOP, 0, 0, 0, st);
    chk("div0_stall", st, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("div0_no_start", start_cnt - s0, 0);
    drain();

    hang = 1;
    send(MULT, 32'd5, 32'd6, 1, st);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (err) break;
      n++;
    end
    chk("wd_cycles", n, 65);
    chk("wd_err", err, 1);
    @(posedge clk);
    #1;
    hang = 0;
    wait_md_idle();
    drain();

    busy_len = 10;
    send(MULT, 32'd3, 32'd4, 0, st);
    repeat (4) @(posedge clk);
    #1;
    hw_reset(1, 0);
    wait_md_idle();
    send(MTLO, 32'h77, 0, 0, st);
    send(MFLO, 0, 0, 0, st);

`ifdef MD_FLUSH_EN
    busy_len = 10;
    send(MULT, 32'd9, 32'd9, 1, st);
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    send(MTLO, 32'h55, 0, 0, st);
    chk("flush_busy_clear", md_busy, 0);
    chk("flush_waited", 64'(st > 0), 1);
    send(MFLO, 0, 0, 0, st);
`endif

    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
